// File: rtl/router_pkg.sv
// Shared definitions for the mesh router XY routing path: packet field layout,
// destination-port encoding and helpers to read/rewrite the signed dx field.
package router_pkg;

    localparam int PKT_W  = 16;
    localparam int DX_LSB = 4;
    localparam int DX_W   = 4;
    localparam int DY_W   = 4;

    typedef enum logic [1:0] {
        PORT_LOCAL = 2'd0,
        PORT_EAST  = 2'd1,
        PORT_DROP  = 2'd2
    } dest_port_t;

    // Pull the two's-complement X offset out of a packet.
    function automatic logic [DX_W-1:0] get_dx(input logic [PKT_W-1:0] pkt);
        return pkt[DX_LSB +: DX_W];
    endfunction

    // Return a copy of the packet with only the dx field replaced.
    function automatic logic [PKT_W-1:0] set_dx(input logic [PKT_W-1:0] pkt,
                                                input logic [DX_W-1:0]  dx);
        logic [PKT_W-1:0] result;
        result = pkt;
        result[DX_LSB +: DX_W] = dx;
        return result;
    endfunction

endpackage

// File: rtl/dx_decode.sv
// Combinational dx decoder: chooses the destination port from the sign and
// magnitude of dx and provides the dx value after one more eastward hop.
module dx_decode
    import router_pkg::*;
(
    input  logic [DX_W-1:0] dx,
    output dest_port_t      port,
    output logic [DX_W-1:0] dx_next
);

    // Negative offsets mean the packet overshot its column; zero means it has
    // arrived; positive means it still needs to travel east.
    always_comb begin
        port    = PORT_LOCAL;
        dx_next = dx - DX_W'(1);
        if (dx[DX_W-1]) begin
            port = PORT_DROP;
        end else if (dx != '0) begin
            port = PORT_EAST;
        end
    end

endmodule

// File: rtl/forward_east_unit.sv
// East-port forwarding stage: registers each valid packet onto the east or
// local output (east copies carry dx reduced by one hop) and drops misrouted
// packets with a one-cycle flag and a saturating drop counter.
module forward_east_unit
    import router_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PKT_W-1:0] packet_in,
    input  logic             valid_in,
    output logic [PKT_W-1:0] packet_east,
    output logic             valid_east,
    output logic [PKT_W-1:0] packet_local,
    output logic             valid_local,
    output logic             misroute,
    output logic [CNT_W-1:0] drop_count
);

    dest_port_t      port;
    logic [DX_W-1:0] dx_next;

    dx_decode u_dx_decode (
        .dx      (get_dx(packet_in)),
        .port    (port),
        .dx_next (dx_next)
    );

    // Output registers: valids/misroute are per-cycle pulses, packet registers
    // only load on their own port so they hold the last delivered packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            packet_east  <= '0;
            valid_east   <= 1'b0;
            packet_local <= '0;
            valid_local  <= 1'b0;
            misroute     <= 1'b0;
            drop_count   <= '0;
        end else begin
            valid_east  <= 1'b0;
            valid_local <= 1'b0;
            misroute    <= 1'b0;
            if (valid_in) begin
                case (port)
                    PORT_EAST: begin
                        packet_east <= set_dx(packet_in, dx_next);
                        valid_east  <= 1'b1;
                    end
                    PORT_LOCAL: begin
                        packet_local <= packet_in;
                        valid_local  <= 1'b1;
                    end
                    default: begin
                        misroute <= 1'b1;
                        if (drop_count != '1) begin
                            drop_count <= drop_count + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_forward_east_unit.sv
// Self-checking bench for forward_east_unit: directed scenarios followed by
// randomized traffic, compared against a simple arithmetic reference model.
module tb_forward_east_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] packet_in;
    logic        valid_in;
    logic [15:0] packet_east;
    logic        valid_east;
    logic [15:0] packet_local;
    logic        valid_local;
    logic        misroute;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_east;
    logic        m_valid_east;
    logic [15:0] m_local;
    logic        m_valid_local;
    logic        m_misroute;
    int          m_drops;

    forward_east_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .packet_in    (packet_in),
        .valid_in     (valid_in),
        .packet_east  (packet_east),
        .valid_east   (valid_east),
        .packet_local (packet_local),
        .valid_local  (valid_local),
        .misroute     (misroute),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the reference model.
    task automatic checkOutput(input string tag);
        check({tag, ".valid_east"},   {31'd0, valid_east},  {31'd0, m_valid_east});
        check({tag, ".valid_local"},  {31'd0, valid_local}, {31'd0, m_valid_local});
        check({tag, ".misroute"},     {31'd0, misroute},    {31'd0, m_misroute});
        check({tag, ".packet_east"},  {16'd0, packet_east}, {16'd0, m_east});
        check({tag, ".packet_local"}, {16'd0, packet_local},{16'd0, m_local});
        check({tag, ".drop_count"},   {24'd0, drop_count},  m_drops);
    endtask

    // Drive one cycle of input, advance the model, then check the outputs.
    task automatic applyStimulus(input logic [15:0] pkt, input logic v,
                                 input logic rst, input string tag);
        logic signed [3:0] dx_field;
        int                dx;
        @(negedge clk);
        packet_in = pkt;
        valid_in  = v;
        rst_n     = rst;
        @(posedge clk);
        #1;
        if (!rst) begin
            m_east = 16'h0000; m_local = 16'h0000; m_drops = 0;
            m_valid_east = 1'b0; m_valid_local = 1'b0; m_misroute = 1'b0;
        end else begin
            m_valid_east = 1'b0; m_valid_local = 1'b0; m_misroute = 1'b0;
            if (v) begin
                dx_field = pkt[7:4];
                dx = dx_field;
                if (dx > 0) begin
                    m_east = pkt - 16'h0010;
                    m_valid_east = 1'b1;
                end else if (dx == 0) begin
                    m_local = pkt;
                    m_valid_local = 1'b1;
                end else begin
                    m_misroute = 1'b1;
                    m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                end
            end
        end
        checkOutput(tag);
    endtask

    initial begin
        logic [15:0] rnd_pkt;
        rst_n = 1'b0; valid_in = 1'b0; packet_in = 16'h0000;
        m_east = 16'h0; m_local = 16'h0; m_drops = 0;
        m_valid_east = 1'b0; m_valid_local = 1'b0; m_misroute = 1'b0;

        // Reset with packets present must not let anything through
        applyStimulus(16'h0020, 1'b1, 1'b0, "reset0");
        applyStimulus(16'hC3F7, 1'b1, 1'b0, "reset1");

        // Basic east, local, and drop cases
        applyStimulus(16'h0020, 1'b1, 1'b1, "east_dx2");
        check("east_dx2.value", {16'd0, packet_east}, 32'h0010);
        applyStimulus(16'h0000, 1'b1, 1'b1, "local_zero");
        applyStimulus(16'hAB05, 1'b1, 1'b1, "local_ab05");
        check("local_ab05.value", {16'd0, packet_local}, 32'hAB05);
        applyStimulus(16'hC3F7, 1'b1, 1'b1, "drop_neg1");
        check("drop_neg1.count", {24'd0, drop_count}, 32'd1);

        // Back-to-back traffic then idle
        applyStimulus(16'h0010, 1'b1, 1'b1, "b2b_east1");
        applyStimulus(16'h0000, 1'b1, 1'b1, "b2b_local");
        applyStimulus(16'h0070, 1'b1, 1'b1, "b2b_east7");
        check("b2b_east7.value", {16'd0, packet_east}, 32'h0060);
        applyStimulus(16'h1234, 1'b0, 1'b1, "idle");

        // Boundary dx values: max positive and most negative
        applyStimulus(16'h5A7C, 1'b1, 1'b1, "dx_max");
        applyStimulus(16'h5A8C, 1'b1, 1'b1, "dx_min");

        // Push the drop counter past saturation with random misrouted packets
        for (int i = 0; i < 270; i++) begin
            rnd_pkt = 16'($urandom) | 16'h0080;
            applyStimulus(rnd_pkt, 1'b1, 1'b1, "sat_drop");
        end
        check("saturated", {24'd0, drop_count}, 32'h00FF);

        // Random mixed traffic, including idle cycles
        for (int i = 0; i < 300; i++) begin
            rnd_pkt = 16'($urandom);
            applyStimulus(rnd_pkt, 1'($urandom_range(0, 3) != 0), 1'b1, "random");
        end

        // Mid-stream reset loses the same-cycle packet and clears the counter
        applyStimulus(16'h0030, 1'b1, 1'b0, "mid_reset");
        applyStimulus(16'h0030, 1'b1, 1'b1, "after_reset");
        applyStimulus(16'h00F0, 1'b1, 1'b1, "after_reset_drop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
